// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: synchroniser, optional debounce (EDGE_DEBOUNCE_EN),
// per-channel edge select, one-cycle pulse and sticky pending/overrun flags.

module edge_detect_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic       pending_o,
    output logic       overrun_o,
    output logic       pending_d_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s, level;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic                   rise, fall, ev;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    assign s      = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int             CW      = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // The counter only runs while s disagrees with level, so it tops out at DB_LAST.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s != level_q) begin
            if (cnt_q == DB_LAST) level_d = s;
            else                  cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = s;
`endif

    always_comb begin
        rise      = level & ~prev_q;
        fall      = ~level & prev_q;
        ev        = (rise & mode_i[0]) | (fall & mode_i[1]);
        prev_d    = level;
        pulse_d   = ev;
        // A clear never drops an event arriving in the same cycle.
        pending_d = ev | (pending_q & ~clr_i);
        overrun_d = clr_i ? 1'b0 : (overrun_q | (ev & pending_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign level_o     = level;
    assign pulse_o     = pulse_q;
    assign pending_o   = pending_q;
    assign overrun_o   = overrun_q;
    assign pending_d_o = pending_d;

endmodule

module edge_detect_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   level,
    output logic [CH-1:0]   pulse,
    output logic [CH-1:0]   pending,
    output logic [CH-1:0]   overrun,
    output logic            any_pending
);

    logic [CH-1:0] pending_d;
    logic          any_pending_q, any_pending_d;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        edge_detect_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .in_i        (in[i]),
            .mode_i      (mode[2*i +: 2]),
            .clr_i       (clr[i]),
            .level_o     (level[i]),
            .pulse_o     (pulse[i]),
            .pending_o   (pending[i]),
            .overrun_o   (overrun[i]),
            .pending_d_o (pending_d[i])
        );
    end

    // Registered from next-state pending so it lines up with pending itself.
    assign any_pending_d = |pending_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) any_pending_q <= 1'b0;
        else      any_pending_q <= any_pending_d;
    end

    assign any_pending = any_pending_q;

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Multi-channel, parametrised edge detector for asynchronous inputs such as keypad and button lines. Each channel has a synchroniser, an optional debounce filter, a per-channel selectable edge mode, a one-cycle event pulse, and a sticky pending flag with clear. It sits between the raw pin inputs and the calculator control FSM, which consumes either the pulses or the pending flags.

Parameters:
CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DB_CYCLES, 16, consecutive stable cycles required before the debounced level changes (>=1; used only with EDGE_DEBOUNCE_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in  input  CH  raw asynchronous inputs
mode  input  2*CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clr  input  CH  per-channel clear of pending/overrun, synchronous, level-sensitive
level  output  CH  synchronised (and debounced) input level
pulse  output  CH  one-cycle event strobe per enabled edge
pending  output  CH  sticky event flag
overrun  output  CH  event arrived while pending already set
any_pending  output  1  OR-reduction of pending

Behaviour:
- rst low: all flops clear immediately without a clock. Synchroniser, level, pulse, pending, overrun and any_pending all read 0; debounce counters read 0.
- Synchroniser: SYNC_STAGES-deep shift register per channel, reset 0. Its output is s[i].
- Debounce (macro on): per-channel counter, width clog2(DB_CYCLES)+1.
  - If s[i]==level[i]: counter <= 0.
  - Otherwise the counter increments. On the DB_CYCLES-th consecutive differing edge, level[i] <= s[i] and counter <= 0.
  - Any return of s[i] to level[i] before then discards the change. The counter never wraps.
- Edge detection is on level[i] transitions only. A registered prev[i] holds the previous level.
  - rise = level & ~prev; fall = ~level & prev.
  - pulse[i] is registered: high for exactly one cycle, on the edge after level[i] changes, only if mode[i] enables that direction.
- Latency, measured from an input change that is stable before a clk edge:
  - level changes SYNC_STAGES+DB_CYCLES edges later.
  - pulse asserts at edge SYNC_STAGES+DB_CYCLES+1.
- mode is sampled at the same edge pulse is computed. A change takes effect on the next transition; no retroactive events.
- pending[i]: set on the edge pulse[i] asserts.
  - clr[i] clears it.
  - Event and clr in the same cycle: pending stays 1 (event never lost) and overrun clears.
- overrun[i]: set when an event occurs while pending[i] is already 1 and clr[i] is low. It stays set until clr[i].
- any_pending is a registered OR of the next-state pending, so it is coincident with pending.
- level resets to 0. An input held high through reset therefore produces a rising transition after latency, and a pulse if rising is enabled. This is intentional; the FSM ignores events in its first cycles.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

Optional Feature:
EDGE_DEBOUNCE_EN
- Defined: debounce counters are instantiated exactly as above.
- Undefined: no counters. level[i] = s[i] registered directly, equivalent to DB_CYCLES=0. Latency is level at edge SYNC_STAGES and pulse at edge SYNC_STAGES+1. DB_CYCLES is ignored.

Test Plan:
1. CH=4, SYNC_STAGES=2, DB_CYCLES=4, macro on, mode=8'h55. Release rst with in=0, then hold in[0] 0->1.
   -> level[0]=1 after edge 6; pulse[0]=1 for exactly one cycle at edge 7; pending[0]=1, any_pending=1; no other channel changes.
2. Glitch: in[1] high for 3 cycles then low.
   -> level[1], pulse[1] and pending[1] stay 0. Then 4+ cycles high -> pulse.
3. mode[5:4]=11: in[2] high 10 cycles then low -> two pulses, both latched pending. mode[5:4]=10: same stimulus -> only the falling pulse. mode=00 -> none.
4. Pending/overrun on ch0:
   -> event gives pending=1; second event without clr gives overrun[0]=1.
   -> clr[0] pulse clears both.
   -> clr[0] coincident with a new pulse gives pending=1, overrun=0.
5. Async reset mid-debounce: drop rst between clock edges while the ch3 counter is at 2.
   -> all outputs 0 before the next edge. Release with in=0 -> no pulse for 20 cycles.
6. Macro off, same params as scenario 1: in[0] 0->1 -> level at edge 2, pulse at edge 3. A 1-cycle glitch of at least one full cycle produces two pulses in mode 11.
